// File: rtl/reg_bank_param.sv
// Parameterised register bank: two combinational read ports, one write port, sequential clear sweep.
// Define REG_BANK_BYPASS_EN to forward a qualifying write's data to matching read ports in the same cycle.
module reg_bank_param #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter bit ZERO_R0 = 1'b0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             we,
  input  logic [AW-1:0]    rs_i,
  input  logic [AW-1:0]    rs2_i,
  input  logic [AW-1:0]    rd_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] rs_o,
  output logic [WIDTH-1:0] rs2_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_qual;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  // A clear request accepted at the same edge takes priority over the write.
  assign wr_qual = cen && we && (state_q == IDLE) && !clr_i;
  assign busy_o  = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = rd_i;
    wr_data = dat_i;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (wr_qual && !(ZERO_R0 && (rd_i == '0))) begin
          wr_en = 1'b1;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
        ptr_d   = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (cen) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_o = mem_q[rs_i];
`ifdef REG_BANK_BYPASS_EN
    if (wr_qual && (rd_i == rs_i)) rs_o = dat_i;
`endif
    if (ZERO_R0 && (rs_i == '0)) rs_o = '0;
  end

  always_comb begin
    rs2_o = mem_q[rs2_i];
`ifdef REG_BANK_BYPASS_EN
    if (wr_qual && (rd_i == rs2_i)) rs2_o = dat_i;
`endif
    if (ZERO_R0 && (rs2_i == '0)) rs2_o = '0;
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: directed scenarios plus random traffic against a behavioural model.
module tb_reg_bank_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cen, we, clr_i, busy_o;
  logic [2:0] rs_i, rs2_i, rd_i;
  logic [7:0] dat_i, rs_o, rs2_o;

  logic        z_cen, z_we, z_clr, z_busy;
  logic [3:0]  z_rs, z_rs2, z_rd;
  logic [15:0] z_dat, z_rs_o, z_rs2_o;

  reg_bank_param dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .we(we), .rs_i(rs_i), .rs2_i(rs2_i),
    .rd_i(rd_i), .dat_i(dat_i), .clr_i(clr_i), .rs_o(rs_o), .rs2_o(rs2_o), .busy_o(busy_o)
  );

  reg_bank_param #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .cen(z_cen), .we(z_we), .rs_i(z_rs), .rs2_i(z_rs2),
    .rd_i(z_rd), .dat_i(z_dat), .clr_i(z_clr), .rs_o(z_rs_o), .rs2_o(z_rs2_o), .busy_o(z_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: register contents, number of sweep writes still owed, and next index to clear.
  logic [7:0] mdl [8];
  int         left;
  int         idx;
  logic       last_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    logic [7:0] v;
    v = mdl[a];
`ifdef REG_BANK_BYPASS_EN
    if (cen && we && !clr_i && (left == 0) && (rd_i == a)) v = dat_i;
`endif
    return v;
  endfunction

  task automatic cycle(input logic c, input logic w, input logic clr, input logic [2:0] rd,
                       input logic [7:0] d, input logic [2:0] a, input logic [2:0] b, input string tag);
    @(negedge clk);
    cen = c; we = w; clr_i = clr; rd_i = rd; dat_i = d; rs_i = a; rs2_i = b;
    #2;
    chk({tag, ".a"}, {24'd0, rs_o}, {24'd0, exp_rd(a)});
    chk({tag, ".b"}, {24'd0, rs2_o}, {24'd0, exp_rd(b)});
    chk({tag, ".busy"}, {31'd0, busy_o}, (left > 0) ? 32'd1 : 32'd0);
    last_busy = busy_o;
    @(posedge clk);
    if (c) begin
      if (left > 0) begin
        mdl[idx] = 8'h00;
        idx      = (idx + 1) % 8;
        left--;
      end else if (clr) begin
        left = 8;
        idx  = 0;
      end else if (w) begin
        mdl[rd] = d;
      end
    end
  endtask

  task automatic zcycle(input logic w, input logic [3:0] rd, input logic [15:0] d,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [15:0] ea, input logic [15:0] eb, input string tag);
    @(negedge clk);
    z_cen = 1'b1; z_we = w; z_clr = 1'b0; z_rd = rd; z_dat = d; z_rs = a; z_rs2 = b;
    #2;
    chk({tag, ".a"}, {16'd0, z_rs_o}, {16'd0, ea});
    chk({tag, ".b"}, {16'd0, z_rs2_o}, {16'd0, eb});
    chk({tag, ".busy"}, {31'd0, z_busy}, 32'd0);
    @(posedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    left = 0;
    idx  = 0;
  endtask

  initial begin
    int cnt;
    logic [15:0] byp15;
    rst_n = 1'b0; cen = 1'b0; we = 1'b0; clr_i = 1'b0;
    rd_i = '0; dat_i = '0; rs_i = '0; rs2_i = '0;
    z_cen = 1'b0; z_we = 1'b0; z_clr = 1'b0; z_rd = '0; z_dat = '0; z_rs = '0; z_rs2 = '0;
    last_busy = 1'b0;
    model_reset();

    #1;
    for (int a = 0; a < 8; a++) begin
      rs_i = 3'(a); rs2_i = 3'(7 - a);
      #1;
      chk("rst.a", {24'd0, rs_o}, 32'd0);
      chk("rst.b", {24'd0, rs2_o}, 32'd0);
    end
    chk("rst.busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1, 1, 0, 3'd3, 8'hA5, 3'd0, 3'd0, "wr3");
    cycle(1, 0, 0, 3'd0, 8'h00, 3'd3, 3'd3, "rd3");

    cycle(1, 1, 0, 3'd5, 8'h3C, 3'd5, 3'd5, "byp");
    cycle(1, 0, 0, 3'd0, 8'h00, 3'd5, 3'd3, "byp.after");

    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 3'(i), 8'(8'h11 * (i + 1)), 3'(i), 3'(7 - i), "fill");
    cycle(1, 0, 1, 3'd0, 8'h00, 3'd2, 3'd7, "clr");
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 0, 3'd0, 8'h00, 3'd2, 3'd7, "sweep");
      if (last_busy) cnt++;
    end
    chk("clr.len", 32'(cnt), 32'd8);
    for (int a = 0; a < 8; a++) cycle(1, 0, 0, 3'd0, 8'h00, 3'(a), 3'(a), "post");

    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 3'(i), 8'(8'h5A ^ i), 3'(i), 3'd4, "refill");
    cycle(1, 1, 1, 3'd4, 8'hFF, 3'd4, 3'd4, "conf");
    for (int k = 0; k < 9; k++) cycle(1, k[0], 0, 3'(k), 8'hEE, 3'd4, 3'(k), "conf.busy");
    cycle(1, 0, 0, 3'd0, 8'h00, 3'd4, 3'd1, "conf.end");

    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 3'(i), 8'(8'hC0 + i), 3'(i), 3'(i), "fill2");
    cycle(1, 0, 1, 3'd0, 8'h00, 3'd6, 3'd1, "clr2");
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      cycle((k < 2 || k > 4) ? 1'b1 : 1'b0, 0, 0, 3'd0, 8'h00, 3'd6, 3'd1, "hold");
      if (last_busy) cnt++;
    end
    chk("hold.len", 32'(cnt), 32'd11);

    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 3'(i), 8'(8'h70 + i), 3'(i), 3'(i), "fill3");
    cycle(1, 0, 1, 3'd0, 8'h00, 3'd0, 3'd0, "clr3");
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 3'd0, 8'h00, 3'd7, 3'd6, "pre.rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", {31'd0, busy_o}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      rs_i = 3'(a); rs2_i = 3'(a);
      #1;
      chk("arst.a", {24'd0, rs_o}, 32'd0);
      chk("arst.b", {24'd0, rs2_o}, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, 1'($urandom), ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
            3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), "rand");
    end

`ifdef REG_BANK_BYPASS_EN
    byp15 = 16'hBEEF;
`else
    byp15 = 16'h0000;
`endif
    zcycle(1, 4'd0,  16'hBEEF, 4'd0,  4'd0,  16'h0000, 16'h0000, "z.wr0");
    zcycle(0, 4'd0,  16'h0000, 4'd0,  4'd15, 16'h0000, 16'h0000, "z.rd0");
    zcycle(1, 4'd15, 16'hBEEF, 4'd15, 4'd0,  byp15,    16'h0000, "z.wr15");
    zcycle(0, 4'd0,  16'h0000, 4'd15, 4'd0,  16'hBEEF, 16'h0000, "z.rd15");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
REG_BANK_PARAM -- requirements
Module: reg_bank_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning data bits per register.
REQ-002 SHALL provide parameter DEPTH, default 8, meaning register count; power of two, >= 2.
REQ-003 SHALL provide parameter ZERO_R0, default 0, meaning when 1 register 0 reads as zero and ignores writes.
REQ-004 SHALL derive AW = clog2(DEPTH) internally; AW is not overridable.
REQ-005 SHALL have port clk  in  1  the single clock, rising-edge active.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cen  in  1  synchronous enable; when low, no state changes (not clock gating).
REQ-008 SHALL have port we  in  1  write request.
REQ-009 SHALL have ports rs_i, rs2_i  in  AW  read addresses, ports A and B.
REQ-010 SHALL have port rd_i  in  AW  write address.
REQ-011 SHALL have port dat_i  in  WIDTH  write data.
REQ-012 SHALL have port clr_i  in  1  request sequential clear of all registers.
REQ-013 SHALL have ports rs_o, rs2_o  out  WIDTH  read data, ports A and B.
REQ-014 SHALL have port busy_o  out  1  clear sweep in progress.

Function
REQ-015 A write SHALL occur at a rising clk edge when cen=1, we=1, busy_o=0, and no clear is accepted at that edge: mem[rd_i] <= dat_i.
REQ-016 Reads SHALL be combinational: rs_o = mem[rs_i], rs2_o = mem[rs2_i]; both ports SHALL be independent, including equal addresses.
REQ-017 With ZERO_R0=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0 on both ports, overriding bypass.
REQ-018 The FSM SHALL have states IDLE and CLEAR, plus an AW-bit sweep pointer.
REQ-019 IDLE -> CLEAR SHALL occur at an edge with cen=1 and clr_i=1; the pointer is set to 0 and busy_o is 1 after that edge.
REQ-020 In CLEAR, each edge with cen=1 SHALL write 0 to mem[pointer] and increment the pointer; the edge clearing index DEPTH-1 SHALL return to IDLE and the pointer wraps to 0.
REQ-021 A clear SHALL take exactly DEPTH enabled cycles after acceptance; busy_o SHALL equal (state == CLEAR).
REQ-022 clr_i and we asserted at the same accepting edge: the clear SHALL win and the write SHALL be discarded.
REQ-023 clr_i while busy_o=1 SHALL be ignored; no restart and no extension.
REQ-024 we while busy_o=1 SHALL be dropped silently, with no queuing.
REQ-025 Reads during CLEAR SHALL return current array contents (partially cleared).
REQ-026 cen=0 SHALL freeze the FSM, pointer and array; reads remain live.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, clear all registers to 0, force IDLE, set the pointer to 0 and set busy_o to 0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep; after release the block is IDLE with all registers 0.
REQ-029 After reset, rs_o and rs2_o SHALL read 0 for every address.

Configuration
REQ-030 Macro REG_BANK_BYPASS_EN defined: when a write qualifies per REQ-015 and rd_i equals a read address, that port SHALL output dat_i combinationally in the same cycle.
REQ-031 REG_BANK_BYPASS_EN undefined: read ports SHALL show the old value until after the write edge; there is no forwarding logic.

Verification
REQ-032 Reset release, write 0xA5 to r3, read rs_i=3 next cycle -> rs_o=0xA5; rs2_i=3 -> rs2_o=0xA5.
REQ-033 Bypass: with the macro on, we=1, rd_i=5, dat_i=0x3C, rs_i=5 in the same cycle -> rs_o=0x3C before the edge; with the macro off -> old value 0x00.
REQ-034 Clear: fill r0..r7 with 0x11..0x88, pulse clr_i -> busy_o high for exactly 8 enabled cycles; r2 reads 0 after the 3rd sweep edge while r7 still reads 0x88; then all read 0.
REQ-035 Conflict: clr_i=1 and we=1 (rd_i=4, dat_i=0xFF) at one edge -> clear starts, r4 ends 0; we pulses during busy_o -> no effect.
REQ-036 cen=0 for 3 cycles mid-sweep -> pointer and busy_o hold, sweep ends 3 cycles late; rst_n low mid-sweep -> busy_o=0 and all registers 0 immediately.
REQ-037 ZERO_R0=1, WIDTH=16, DEPTH=16: write 0xBEEF to r0 -> reads 0; write to r15 -> reads 0xBEEF.
